// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Scoreboard rd field width; the register address is zero-extended into it.
    localparam int c_RD_W = 8;

    localparam int c_SEL_RF = 0;
    localparam int c_SEL_E  = 1;

    localparam int c_STG_E = 0;
    localparam int c_STG_M = 1;
    localparam int c_STG_W = 2;

    typedef struct packed {
        logic              valid;
        logic [c_RD_W-1:0] rd;
        logic              wb;
        logic              load;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Scoreboard-based forwarding, stall and flush control for the
//               five-stage pipeline, with saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter  int REG_AW     = 5,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_STAGE = 1,
    parameter  int FWD_EN     = 1,
    parameter  int CNT_W      = 32,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_rs1_used,
    input  logic              d_rs2_used,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_wb_en,
    input  logic              d_is_load,
    input  logic              e_brn_tkn,
    output logic              stall_fd,
    output logic              bubble_e,
    output logic              flush_fd,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    sb_entry_t         r_sb [DEPTH];
    sb_entry_t         w_new;
    logic [c_RD_W-1:0] w_rs1_x;
    logic [c_RD_W-1:0] w_rs2_x;
    logic              w_chk_a;
    logic              w_chk_b;
    logic [DEPTH-1:0]  w_hit_a;
    logic [DEPTH-1:0]  w_hit_b;
    logic              w_stall_a;
    logic              w_stall_b;
    logic [SEL_W-1:0]  w_sel_a;
    logic [SEL_W-1:0]  w_sel_b;

    assign w_rs1_x = c_RD_W'(d_rs1);
    assign w_rs2_x = c_RD_W'(d_rs2);
    assign w_chk_a = d_valid & d_rs1_used & (d_rs1 != '0);
    assign w_chk_b = d_valid & d_rs2_used & (d_rs2 != '0);

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_match
            assign w_hit_a[k] = r_sb[k].valid & r_sb[k].wb & (r_sb[k].rd == w_rs1_x);
            assign w_hit_b[k] = r_sb[k].valid & r_sb[k].wb & (r_sb[k].rd == w_rs2_x);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        w_stall_a = 1'b0;
        w_stall_b = 1'b0;
        w_sel_a   = SEL_W'(c_SEL_RF);
        w_sel_b   = SEL_W'(c_SEL_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_chk_a && w_hit_a[k]) begin
                if ((FWD_EN == 0) || (r_sb[k].load && (k < LOAD_STAGE))) begin
                    w_stall_a = 1'b1;
                    w_sel_a   = SEL_W'(c_SEL_RF);
                end else begin
                    w_stall_a = 1'b0;
                    w_sel_a   = SEL_W'(c_SEL_E + k);
                end
            end
            if (w_chk_b && w_hit_b[k]) begin
                if ((FWD_EN == 0) || (r_sb[k].load && (k < LOAD_STAGE))) begin
                    w_stall_b = 1'b1;
                    w_sel_b   = SEL_W'(c_SEL_RF);
                end else begin
                    w_stall_b = 1'b0;
                    w_sel_b   = SEL_W'(c_SEL_E + k);
                end
            end
        end
    end

    assign flush_fd  = e_brn_tkn & r_sb[0].valid;
    assign stall_fd  = (w_stall_a | w_stall_b) & ~flush_fd;
    assign bubble_e  = stall_fd | flush_fd;
    assign fwd_a_sel = bubble_e ? SEL_W'(c_SEL_RF) : w_sel_a;
    assign fwd_b_sel = bubble_e ? SEL_W'(c_SEL_RF) : w_sel_b;

    always_comb begin
        w_new       = '0;
        w_new.valid = d_valid;
        w_new.rd    = c_RD_W'(d_rd);
        w_new.wb    = d_wb_en & (d_rd != '0);
        w_new.load  = d_is_load;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            r_sb[0] <= bubble_e ? sb_entry_t'('0) : w_new;
            for (int k = 1; k < DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_inc   (stall_fd),
        .o_count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_inc   (flush_fd),
        .o_count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed bench for hazard_unit: default, no-forwarding and
//               narrow-counter instances driven from one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs1;
    logic [4:0] d_rs2;
    logic       d_rs1_used;
    logic       d_rs2_used;
    logic [4:0] d_rd;
    logic       d_wb_en;
    logic       d_is_load;
    logic       e_brn_tkn;

    logic        stall0, bubble0, flush0;
    logic [1:0]  sa0, sb0;
    logic [31:0] scnt0, fcnt0;
    logic        stall1, bubble1, flush1;
    logic [1:0]  sa1, sb1;
    logic [31:0] scnt1, fcnt1;
    logic        stall2, bubble2, flush2;
    logic [1:0]  sa2, sb2;
    logic [3:0]  scnt2, fcnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    hazard_unit u_dut0 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_wb_en(d_wb_en),
        .d_is_load(d_is_load), .e_brn_tkn(e_brn_tkn), .stall_fd(stall0), .bubble_e(bubble0),
        .flush_fd(flush0), .fwd_a_sel(sa0), .fwd_b_sel(sb0), .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    hazard_unit #(.FWD_EN(0)) u_dut1 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_wb_en(d_wb_en),
        .d_is_load(d_is_load), .e_brn_tkn(e_brn_tkn), .stall_fd(stall1), .bubble_e(bubble1),
        .flush_fd(flush1), .fwd_a_sel(sa1), .fwd_b_sel(sb1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    hazard_unit #(.FWD_EN(0), .CNT_W(4)) u_dut2 (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_wb_en(d_wb_en),
        .d_is_load(d_is_load), .e_brn_tkn(e_brn_tkn), .stall_fd(stall2), .bubble_e(bubble2),
        .flush_fd(flush2), .fwd_a_sel(sa2), .fwd_b_sel(sb2), .stall_cnt(scnt2), .flush_cnt(fcnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic wb, input logic ld, input logic brn);
        d_valid    = v;
        d_rs1      = rs1;
        d_rs2      = rs2;
        d_rs1_used = u1;
        d_rs2_used = u2;
        d_rd       = rd;
        d_wb_en    = wb;
        d_is_load  = ld;
        e_brn_tkn  = brn;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        check_eq("rst_stall",  32'(stall0),  0);
        check_eq("rst_bubble", 32'(bubble0), 0);
        check_eq("rst_flush",  32'(flush0),  0);
        check_eq("rst_sela",   32'(sa0),     0);
        check_eq("rst_scnt",   scnt0,        0);
        check_eq("rst_fcnt",   fcnt0,        0);
        reset = 1'b0;

        // ALU chain: x5 then x8 through E, M, W and retired
        tick();
        drive(1, 1, 0, 1, 0, 5, 1, 0, 0);
        #1 check_eq("alu0_sela", 32'(sa0), 0);
        tick();
        drive(1, 5, 9, 1, 1, 8, 1, 0, 0);
        #1 check_eq("alu1_sela", 32'(sa0), 1);
        check_eq("alu1_selb",  32'(sb0),    0);
        check_eq("alu1_stall", 32'(stall0), 0);
        tick();
        drive(1, 5, 8, 1, 1, 0, 0, 0, 0);
        #1 check_eq("alu2_sela", 32'(sa0), 2);
        check_eq("alu2_selb", 32'(sb0), 1);
        tick();
        #1 check_eq("alu3_sela", 32'(sa0), 3);
        check_eq("alu3_selb", 32'(sb0), 2);
        tick();
        #1 check_eq("alu4_sela", 32'(sa0), 0);
        check_eq("alu4_selb", 32'(sb0), 3);
        tick();
        idle(3);

        // Load-use: one stall cycle then forward from M
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
        #1 check_eq("lu0_stall", 32'(stall0), 0);
        tick();
        drive(1, 2, 6, 0, 1, 7, 1, 0, 0);
        #1 check_eq("lu1_stall", 32'(stall0), 1);
        check_eq("lu1_bubble", 32'(bubble0), 1);
        check_eq("lu1_selb",   32'(sb0),     0);
        tick();
        #1 check_eq("lu2_stall", 32'(stall0), 0);
        check_eq("lu2_bubble", 32'(bubble0), 0);
        check_eq("lu2_selb",   32'(sb0),     2);
        check_eq("lu2_scnt",   scnt0,        1);
        tick();
        idle(3);

        // x0 destination/source and unused operand never hazard
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        drive(1, 0, 0, 1, 1, 4, 0, 0, 0);
        #1 check_eq("x0_stall", 32'(stall0), 0);
        check_eq("x0_sela", 32'(sa0), 0);
        tick();
        idle(3);
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
        tick();
        drive(1, 3, 6, 1, 0, 4, 0, 0, 0);
        #1 check_eq("unused_stall", 32'(stall0), 0);
        check_eq("unused_selb", 32'(sb0), 0);
        tick();
        idle(3);

        // Flush beats a simultaneous load-use stall
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
        tick();
        drive(1, 6, 0, 1, 0, 4, 1, 0, 1);
        #1 check_eq("fl_flush", 32'(flush0), 1);
        check_eq("fl_stall",  32'(stall0),  0);
        check_eq("fl_bubble", 32'(bubble0), 1);
        check_eq("fl_sela",   32'(sa0),     0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 check_eq("fl_ignored", 32'(flush0), 0);
        check_eq("fl_fcnt", fcnt0, 1);
        check_eq("fl_scnt", scnt0, 1);
        tick();
        idle(1);

        // No forwarding: stall until the producer retires from W
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive(1, 7, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check_eq($sformatf("nofwd_stall%0d", i), 32'(stall1), 1);
            check_eq($sformatf("nofwd_sel%0d", i), 32'(sa1), 0);
            tick();
        end
        #1 check_eq("nofwd_done", 32'(stall1), 0);
        check_eq("nofwd_sel", 32'(sa1), 0);
        check_eq("nofwd_scnt", scnt1, 3);
        tick();
        idle(3);

        // Reset in the middle of a stall, then counter saturation
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive(1, 7, 0, 1, 0, 0, 0, 0, 0);
        #1 check_eq("mid_stall0", 32'(stall2), 1);
        tick();
        #1 check_eq("mid_scnt", 32'(scnt2), 4);
        reset = 1'b1;
        tick();
        #1 check_eq("mid_rst_stall", 32'(stall2), 0);
        check_eq("mid_rst_scnt", 32'(scnt2), 0);
        check_eq("mid_rst_scnt0", scnt0, 0);
        reset = 1'b0;
        tick();
        #1 check_eq("mid_after_stall", 32'(stall2), 0);
        drive(1, 7, 0, 1, 0, 7, 1, 0, 0);
        for (int i = 0; i < 40; i++) tick();
        #1 check_eq("sat_scnt", 32'(scnt2), 15);
        check_eq("sat_fcnt", 32'(fcnt2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
